key_press_emulator: RTL and testbench
=====================================

Name: key_press_emulator

Overview:
- Synthesizable mechanical-key model that generates an active-low, bouncy key waveform from a single-cycle press request.
- Drives key inputs of debounce logic for on-board self-test and for closed-loop simulation without a physical button.
- Each request produces a full press/release cycle: pseudo-random bounce on the falling edge, a clean low hold, then pseudo-random bounce on the rising edge.

Parameters:
BOUNCE_CYC, 20'd250_000, length of each bounce window in sys_clk cycles (5 ms at 50 MHz); legal range 2..2^20-1
TOG_W, 8, width of the LFSR slice that sets the toggle interval; legal range 1..16; interval is lfsr[TOG_W-1:0]+1 cycles
BOUNCE_EN, 1'b1, 1 = bounce toggles enabled, 0 = clean edges only
LFSR_SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001

Ports:
sys_clk  input  1  system clock, rising edge
sys_rst_n  input  1  reset, asynchronous, active-low
press_req  input  1  single-cycle request to start one press/release cycle
hold_cyc  input  24  clean-low hold length in cycles; sampled only on an accepted press_req; 0 is treated as 1
key_out  output  1  emulated key, active-low (1 = released)
busy  output  1  high while a press/release cycle is in progress
done  output  1  one-cycle pulse when a cycle completes
press_cnt  output  8  count of completed cycles, wraps 255 -> 0

Behaviour:
- Reset is asynchronous, active-low, on sys_rst_n; clock is sys_clk.
- Reset values: key_out=1, busy=0, done=0, press_cnt=0, state=IDLE, all counters=0, LFSR=LFSR_SEED.
- All outputs are registered.
- Reset asserted mid-cycle forces key_out=1 immediately; no done pulse is generated and press_cnt is unchanged.
- FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE.
- busy = (state != IDLE).
- IDLE:
  - key_out=1.
  - press_req=1 at edge E0: latch H = max(hold_cyc,1), set key_out<=0, win_cnt<=0, tog_cnt<=lfsr[TOG_W-1:0], go to PRESS_BOUNCE.
- PRESS_BOUNCE (exactly BOUNCE_CYC cycles):
  - win_cnt increments every cycle.
  - tog_cnt decrements every cycle.
  - When tog_cnt==0 and BOUNCE_EN=1: toggle key_out, advance LFSR one step, reload tog_cnt from the new lfsr[TOG_W-1:0].
  - On the cycle where win_cnt==BOUNCE_CYC-1: no toggle; force key_out<=0, hold_cnt<=0, go to HOLD.
- HOLD:
  - key_out held at 0.
  - When hold_cnt==H-1: key_out<=1, win_cnt<=0, reload tog_cnt, go to RELEASE_BOUNCE.
- RELEASE_BOUNCE:
  - Same toggle rules as PRESS_BOUNCE.
  - On its last cycle: force key_out<=1, done<=1, press_cnt<=press_cnt+1 (mod 256), go to IDLE.
- Timing relative to E0:
  - key_out first low after E0.
  - Clean low from E0+BOUNCE_CYC through E0+BOUNCE_CYC+H.
  - Final rise after E0+BOUNCE_CYC+H.
  - done high for exactly one cycle after edge E0+2*BOUNCE_CYC+H.
  - busy falls in the same cycle done rises.
- press_req while busy=1 is ignored with no queuing, including press_req in the cycle done is high.
- press_req in IDLE is accepted in the cycle immediately after done.
- hold_cyc changes while busy have no effect.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400.
  - Advances only on toggle events, so the bounce pattern is deterministic from reset for a given request sequence.
- BOUNCE_EN=0: key_out is a single clean low pulse of BOUNCE_CYC+H cycles; overall timing is unchanged.
- Counter widths: win_cnt 20 bits, hold_cnt 24 bits, tog_cnt TOG_W bits; none wraps within legal parameter ranges.

Decomposition:
- Shared package holds:
  - FSM state encoding as 2-bit localparams: IDLE=0, PRESS_BOUNCE=1, HOLD=2, RELEASE_BOUNCE=3.
  - LFSR taps constant 16'hB400.
  - Default BOUNCE_CYC constant, shared with the debounce blocks so both agree on the 5 ms window.
- One natural sub-module, lfsr16_galois: ports clk, rst_n, step, seed parameter, q[15:0]. It is reusable for other stimulus blocks.

Test Plan:
1. Reset, no request: key_out=1, busy=0, done=0, press_cnt=0 held for 1000 cycles.
2. BOUNCE_EN=0, BOUNCE_CYC=20, hold_cyc=50, press_req at E0:
   - key_out low for exactly 70 cycles.
   - done single pulse after E0+90.
   - press_cnt=1.
3. BOUNCE_EN=1, TOG_W=3, BOUNCE_CYC=20, hold_cyc=50:
   - at least one toggle in each bounce window; no toggle gap exceeds 8 cycles.
   - key_out stable 0 from E0+20 through E0+70; stable 1 after E0+90.
   - done after E0+90.
4. Ignored requests: press_req pulses at E0+5, at E0+60, and in the done cycle are all ignored; exactly one done, press_cnt=1. A press_req one cycle after done starts a new cycle.
5. hold_cyc=0 behaves as 1: with BOUNCE_CYC=20, done after E0+41.
6. Mid-cycle reset and wrap:
   - sys_rst_n low at E0+30 gives key_out=1 and busy=0 asynchronously; no done; LFSR back to seed (same bounce pattern on the next run).
   - 256 completed cycles return press_cnt to 0.

Source files
------------

// File: rtl/key_press_emulator_pkg.sv
// Shared definitions for the key press emulator and its stimulus companions:
// FSM encoding, LFSR polynomial and the default bounce window.
package key_press_emulator_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    PRESS_BOUNCE   = 2'd1,
    HOLD           = 2'd2,
    RELEASE_BOUNCE = 2'd3
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 5 ms at 50 MHz; the debounce blocks use the same window.
  localparam logic [19:0] BOUNCE_CYC_DEFAULT = 20'd250_000;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/key_press_emulator_if.sv
// Request/key bundle between a press requester (master) and the emulator (slave).
interface key_press_emulator_if;
  import key_press_emulator_pkg::*;

  // press_req is a one-cycle request with no ready: it is taken only when
  // busy=0 and done=0, otherwise dropped; hold_cyc is sampled with it.
  logic        press_req;
  logic [23:0] hold_cyc;
  logic        key_out;
  logic        busy;
  logic        done;
  logic [7:0]  press_cnt;
  state_e      state_dbg;

  modport master (
    output press_req, hold_cyc,
    input  key_out, busy, done, press_cnt, state_dbg
  );

  modport slave (
    input  press_req, hold_cyc,
    output key_out, busy, done, press_cnt, state_dbg
  );

endinterface

// File: rtl/key_press_emulator_lfsr16_galois.sv
// 16-bit Galois LFSR that advances only when step is high; a zero seed
// would lock up, so it is replaced by 1.
module lfsr16_galois
  import key_press_emulator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] q
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED_EFF;
    end else if (step) begin
      q_q <= lfsr16_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/key_press_emulator.sv
// Mechanical key model: one request yields a bouncy active-low press, a clean
// hold of hold_cyc cycles and a bouncy release, then a done pulse.
module key_press_emulator
  import key_press_emulator_pkg::*;
#(
  parameter logic [19:0] BOUNCE_CYC = BOUNCE_CYC_DEFAULT,
  parameter int unsigned TOG_W      = 8,
  parameter bit          BOUNCE_EN  = 1'b1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  key_press_emulator_if.slave   kp
);

  typedef logic [TOG_W-1:0] tog_t;

  state_e      state_q, state_d;
  logic        key_q, key_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] win_q, win_d;
  logic [23:0] hold_q, hold_d;
  logic [23:0] h_q, h_d;
  tog_t        tog_q, tog_d;
  logic [15:0] lfsr_q;
  logic        step;
  logic        win_last;

  lfsr16_galois #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .step  (step),
    .q     (lfsr_q)
  );

  assign win_last = (win_q == BOUNCE_CYC - 20'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      key_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= 8'd0;
      win_q   <= 20'd0;
      hold_q  <= 24'd0;
      h_q     <= 24'd0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      h_q     <= h_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    win_d   = win_q;
    hold_d  = hold_q;
    h_d     = h_q;
    tog_d   = tog_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        key_d = 1'b1;
        // A request landing in the done cycle is dropped, not queued.
        if (kp.press_req && !done_q) begin
          h_d     = (kp.hold_cyc == 24'd0) ? 24'd1 : kp.hold_cyc;
          key_d   = 1'b0;
          win_d   = 20'd0;
          tog_d   = tog_t'(lfsr_q);
          state_d = PRESS_BOUNCE;
        end
      end
      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (win_last) begin
          if (state_q == PRESS_BOUNCE) begin
            key_d   = 1'b0;
            hold_d  = 24'd0;
            state_d = HOLD;
          end else begin
            key_d   = 1'b1;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = IDLE;
          end
        end else begin
          win_d = win_q + 20'd1;
          if (tog_q == '0) begin
            if (BOUNCE_EN) begin
              key_d = ~key_q;
              step  = 1'b1;
              tog_d = tog_t'(lfsr16_next(lfsr_q));
            end else begin
              tog_d = tog_t'(lfsr_q);
            end
          end else begin
            tog_d = tog_q - 1'b1;
          end
        end
      end
      HOLD: begin
        key_d = 1'b0;
        if (hold_q == h_q - 24'd1) begin
          key_d   = 1'b1;
          win_d   = 20'd0;
          tog_d   = tog_t'(lfsr_q);
          state_d = RELEASE_BOUNCE;
        end else begin
          hold_d = hold_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kp.key_out   = key_q;
  assign kp.busy      = (state_q != IDLE);
  assign kp.done      = done_q;
  assign kp.press_cnt = cnt_q;
  assign kp.state_dbg = state_q;

endmodule

// File: tb/tb_key_press_emulator.sv
// Bench for key_press_emulator: a clean-edge instance and a bouncing instance
// share stimulus and are checked every cycle against a waveform model.
module tb_key_press_emulator;
  import key_press_emulator_pkg::*;

  localparam int          BC    = 20;
  localparam int          TW    = 3;
  localparam logic [15:0] TMASK = 16'h0007;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          MAXK  = 255;

  // ---------------- clock / reset ----------------
  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        press_req = 1'b0;
  logic [23:0] hold_cyc  = 24'd0;
  logic        chk_en    = 1'b0;

  always #5 sys_clk = ~sys_clk;

  key_press_emulator_if if_a ();
  key_press_emulator_if if_b ();

  assign if_a.press_req = press_req;
  assign if_a.hold_cyc  = hold_cyc;
  assign if_b.press_req = press_req;
  assign if_b.hold_cyc  = hold_cyc;

  key_press_emulator #(
    .BOUNCE_CYC (20'(BC)), .TOG_W (TW), .BOUNCE_EN (1'b0), .LFSR_SEED (SEED)
  ) dut_a (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .kp (if_a)
  );

  key_press_emulator #(
    .BOUNCE_CYC (20'(BC)), .TOG_W (TW), .BOUNCE_EN (1'b1), .LFSR_SEED (SEED)
  ) dut_b (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .kp (if_b)
  );

  // ---------------- scoreboard counters ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      if (tests_failed <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // On acceptance the whole expected waveform (offset k = edges after E0) is
  // laid out from the bounce/hold/release rules; later edges just replay it.
  logic        wa [0:MAXK];
  logic        wb [0:MAXK];
  int          m_k = 0, m_n = 0, m_h = 1;
  logic        m_busy = 1'b0, m_done = 1'b0, mka = 1'b1, mkb = 1'b1;
  logic [7:0]  m_cnt = 8'd0;
  logic [15:0] m_lfsr = SEED;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic build_wave(input int h);
    int   r;
    logic kb;
    m_n = 2 * BC + h;
    kb  = 1'b0;
    r   = int'(m_lfsr & TMASK);
    wa[0] = 1'b0;
    wb[0] = 1'b0;
    for (int k = 1; k <= m_n; k++) begin
      if ((k < BC) || (k > BC + h && k < m_n)) begin
        if (r == 0) begin
          kb     = ~kb;
          m_lfsr = galois(m_lfsr);
          r      = int'(m_lfsr & TMASK);
        end else begin
          r--;
        end
      end else if (k == BC) begin
        kb = 1'b0;
      end else if (k == BC + h) begin
        kb = 1'b1;
        r  = int'(m_lfsr & TMASK);
      end else if (k == m_n) begin
        kb = 1'b1;
      end
      wa[k] = (k < BC + h) ? 1'b0 : 1'b1;
      wb[k] = kb;
    end
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 8'd0; m_k = 0;
      m_lfsr = SEED; mka = 1'b1; mkb = 1'b1;
    end else if (m_busy) begin
      m_k++;
      mka = wa[m_k];
      mkb = wb[m_k];
      if (m_k == m_n) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_cnt++;
      end
    end else begin
      if (press_req && !m_done) begin
        m_h = (hold_cyc == 24'd0) ? 1 : int'(hold_cyc);
        build_wave(m_h);
        m_k = 0; m_busy = 1'b1; mka = 1'b0; mkb = 1'b0;
      end
      m_done = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("key_a",  32'(if_a.key_out),   32'(mka));
      check("key_b",  32'(if_b.key_out),   32'(mkb));
      check("busy_a", 32'(if_a.busy),      32'(m_busy));
      check("busy_b", 32'(if_b.busy),      32'(m_busy));
      check("done_a", 32'(if_a.done),      32'(m_done));
      check("done_b", 32'(if_b.done),      32'(m_done));
      check("cnt_a",  32'(if_a.press_cnt), 32'(m_cnt));
      check("cnt_b",  32'(if_b.press_cnt), 32'(m_cnt));
      check("state_b_busy", 32'(if_b.state_dbg != IDLE), 32'(m_busy));
    end
  end

  // ---------------- driver ----------------
  logic       ka_tr [0:MAXK];
  logic       kb_tr [0:MAXK];
  logic       dn_tr [0:MAXK];
  logic       by_tr [0:MAXK];
  logic [7:0] cn_tr [0:MAXK];
  logic       req_mask [0:MAXK];

  task automatic clear_mask();
    for (int i = 0; i <= MAXK; i++) req_mask[i] = 1'b0;
  endtask

  // Request at the next edge (E0), then sample after edges E0+0..E0+n.
  // req_mask[k] raises press_req so that it is sampled at edge E0+k.
  task automatic run_press(input logic [23:0] h, input int n, input int chg_k, input logic [23:0] h2);
    @(negedge sys_clk);
    hold_cyc  = h;
    press_req = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge sys_clk);
      ka_tr[k] = if_a.key_out;
      kb_tr[k] = if_b.key_out;
      dn_tr[k] = if_a.done;
      by_tr[k] = if_a.busy;
      cn_tr[k] = if_a.press_cnt;
      press_req = (k < MAXK) ? req_mask[k+1] : 1'b0;
      if (k == chg_k) hold_cyc = h2;
    end
    press_req = 1'b0;
  endtask

  function automatic int count_low_a(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (ka_tr[k] == 1'b0) c++;
    return c;
  endfunction

  function automatic int count_val_b(input int lo, input int hi, input logic v);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (kb_tr[k] == v) c++;
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) if (dn_tr[k]) c++;
    return c;
  endfunction

  task automatic check_press_pattern(input string tag);
    check({tag, "_kb1"},  32'(kb_tr[1]),  32'd0);
    check({tag, "_kb2"},  32'(kb_tr[2]),  32'd1);
    check({tag, "_kb3"},  32'(kb_tr[3]),  32'd0);
    check({tag, "_kb4"},  32'(kb_tr[4]),  32'd1);
    check({tag, "_kb8"},  32'(kb_tr[8]),  32'd1);
    check({tag, "_kb9"},  32'(kb_tr[9]),  32'd0);
    check({tag, "_kb16"}, 32'(kb_tr[16]), 32'd1);
    check({tag, "_kb19"}, 32'(kb_tr[19]), 32'd1);
    check({tag, "_kb20"}, 32'(kb_tr[20]), 32'd0);
  endtask

  task automatic check_window(input string tag, input int lo, input int hi);
    int tog = 0, last = lo - 1, gap = 0;
    for (int k = lo; k <= hi; k++) begin
      if (kb_tr[k] != kb_tr[k-1]) begin
        tog++;
        if (k - last > gap) gap = k - last;
        last = k;
      end
    end
    check({tag, "_toggled"}, 32'(tog >= 1), 32'd1);
    check({tag, "_gap_le8"}, 32'(gap <= 8), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;
    clear_mask();
    #3 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk_en    = 1'b1;

    // 1: idle after reset
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      if (if_a.key_out !== 1'b1 || if_b.key_out !== 1'b1 || if_a.busy !== 1'b0 ||
          if_b.done !== 1'b0 || if_b.press_cnt !== 8'd0) bad++;
    end
    check("idle_1000", 32'(bad), 32'd0);
    check("idle_state", 32'(if_b.state_dbg), 32'(IDLE));

    // 2/3: hold 50, both instances
    run_press(24'd50, 100, -1, 24'd0);
    check("clean_low_len", 32'(count_low_a(0, 100)), 32'd70);
    check("clean_low_k69", 32'(ka_tr[69]), 32'd0);
    check("clean_hi_k70",  32'(ka_tr[70]), 32'd1);
    check("done_k89", 32'(dn_tr[89]), 32'd0);
    check("done_k90", 32'(dn_tr[90]), 32'd1);
    check("done_k91", 32'(dn_tr[91]), 32'd0);
    check("busy_k89", 32'(by_tr[89]), 32'd1);
    check("busy_k90", 32'(by_tr[90]), 32'd0);
    check("cnt_after_1", 32'(cn_tr[100]), 32'd1);
    check_press_pattern("first");
    check_window("press_win", 1, 19);
    check_window("rel_win", 71, 89);
    check("b_hold_low", 32'(count_val_b(20, 69, 1'b1)), 32'd0);
    check("b_after_hi", 32'(count_val_b(90, 100, 1'b0)), 32'd0);

    // 4: ignored requests, hold change while busy, restart right after done
    clear_mask();
    req_mask[5] = 1'b1; req_mask[60] = 1'b1; req_mask[91] = 1'b1; req_mask[92] = 1'b1;
    run_press(24'd50, 140, 10, 24'd3);
    check("ign_one_done", 32'(count_done(0, 91)), 32'd1);
    check("ign_done_k90", 32'(dn_tr[90]), 32'd1);
    check("ign_busy_k91", 32'(by_tr[91]), 32'd0);
    check("ign_restart",  32'(by_tr[92]), 32'd1);
    check("ign_cnt_k91",  32'(cn_tr[91]), 32'd2);
    check("restart_done", 32'(dn_tr[92 + 2 * BC + 3]), 32'd1);
    check("cnt_after_4",  32'(cn_tr[140]), 32'd3);
    clear_mask();

    // 5: zero hold behaves as one
    run_press(24'd0, 45, -1, 24'd0);
    check("h0_done_k40", 32'(dn_tr[40]), 32'd0);
    check("h0_done_k41", 32'(dn_tr[41]), 32'd1);
    check("h0_low_len",  32'(count_low_a(0, 45)), 32'd21);

    // 6a: mid-cycle asynchronous reset
    run_press(24'd50, 29, -1, 24'd0);
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_key_a",  32'(if_a.key_out), 32'd1);
    check("rst_key_b",  32'(if_b.key_out), 32'd1);
    check("rst_busy_b", 32'(if_b.busy),    32'd0);
    check("rst_done_b", 32'(if_b.done),    32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run_press(24'd50, 100, -1, 24'd0);
    check_press_pattern("after_rst");
    check("rst_run_done", 32'(dn_tr[90]), 32'd1);
    check("rst_run_cnt",  32'(cn_tr[100]), 32'd1);

    // 6b: press counter wrap
    for (int i = 0; i < 255; i++) begin
      run_press(24'd1, 42, -1, 24'd0);
      if (i == 253) check("cnt_255", 32'(if_b.press_cnt), 32'd255);
    end
    check("cnt_wrap_a", 32'(if_a.press_cnt), 32'd0);
    check("cnt_wrap_b", 32'(if_b.press_cnt), 32'd0);

    repeat (5) @(negedge sys_clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
